// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse decoder symbol path.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic MORSE_DOT  = 1'b0;
  localparam logic MORSE_DASH = 1'b1;

  localparam int unsigned DEFAULT_MAX_SYMS = 5;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw Morse key, with rise/fall detection
// on the synchronised level.
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise,
  output logic fall
);

  logic stage;
  logic key_s;
  logic key_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
    end else begin
      stage <= key;
      key_s <= stage;
      key_d <= key_s;
    end
  end

  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;

endmodule

// File: rtl/morse_symbol_capture.sv
// Measures key mark/space durations in timer ticks, packs dots and dashes
// into a letter code and emits letter and word-gap events.
module morse_symbol_capture
  import morse_pkg::*;
#(
  parameter int unsigned DASH_TICKS       = 2,
  parameter int unsigned LETTER_GAP_TICKS = 3,
  parameter int unsigned WORD_GAP_TICKS   = 7,
  parameter int unsigned MAX_SYMS         = DEFAULT_MAX_SYMS,
  parameter int unsigned CNT_W            = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                key,
  input  logic                clear,
  output logic                timer_enable,
  output logic                letter_valid,
  output logic [MAX_SYMS-1:0] letter_bits,
  output logic [2:0]          letter_len,
  output logic                letter_err,
  output logic                word_gap
);

  localparam logic [CNT_W-1:0] DASH_CNT   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LETTER_CNT = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WORD_CNT   = CNT_W'(WORD_GAP_TICKS);
  localparam logic [2:0]       MAX_LEN    = 3'(MAX_SYMS);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [MAX_SYMS-1:0] bits;
  logic [2:0]          len;
  logic                ovf;
  logic                sym;
  logic                rise;
  logic                fall;

  key_sync u_key_sync (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    sym     = (cnt >= DASH_CNT) ? MORSE_DASH : MORSE_DOT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bits         <= '0;
      len          <= '0;
      ovf          <= 1'b0;
      timer_enable <= 1'b0;
      letter_valid <= 1'b0;
      letter_bits  <= '0;
      letter_len   <= '0;
      letter_err   <= 1'b0;
      word_gap     <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      word_gap     <= 1'b0;
      timer_enable <= (state != IDLE);
      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
        bits  <= '0;
        len   <= '0;
        ovf   <= 1'b0;
      end else begin
        // Key edges are checked before tick so a coincident tick is dropped.
        case (state)
          IDLE: begin
            if (rise) begin
              state <= MARK;
              cnt   <= '0;
            end
          end
          MARK: begin
            if (fall) begin
              if (len < MAX_LEN) begin
                bits <= {bits[MAX_SYMS-2:0], sym};
                len  <= len + 3'd1;
              end else begin
                ovf <= 1'b1;
              end
              state <= SPACE;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= cnt_inc;
            end
          end
          SPACE: begin
            if (rise) begin
              state <= MARK;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= cnt_inc;
              if (cnt_inc == LETTER_CNT && len != 3'd0) begin
                letter_valid <= 1'b1;
                letter_bits  <= bits;
                letter_len   <= len;
                letter_err   <= ovf;
                bits         <= '0;
                len          <= '0;
                ovf          <= 1'b0;
              end
              if (cnt_inc == WORD_CNT) begin
                word_gap <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Directed bench for morse_symbol_capture: a table of keyed letters plus
// hand-written sequences for reset, clear, saturation and edge/tick races.
module tb_morse_symbol_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       key = 1'b0;
  logic       clear = 1'b0;
  logic       timer_enable;
  logic       letter_valid;
  logic [4:0] letter_bits;
  logic [2:0] letter_len;
  logic       letter_err;
  logic       word_gap;

  int checks = 0;
  int errors = 0;

  morse_symbol_capture #(
    .DASH_TICKS       (2),
    .LETTER_GAP_TICKS (3),
    .WORD_GAP_TICKS   (7),
    .MAX_SYMS         (5),
    .CNT_W            (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .key          (key),
    .clear        (clear),
    .timer_enable (timer_enable),
    .letter_valid (letter_valid),
    .letter_bits  (letter_bits),
    .letter_len   (letter_len),
    .letter_err   (letter_err),
    .word_gap     (word_gap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int unsigned nsym;
    logic [7:0]  mask;  // bit i = 1: symbol i (first keyed = 0) is a dash
    logic [4:0]  bits;
    logic [2:0]  len;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press();
    key = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_key();
    key = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_symbols(input int unsigned nsym, input logic [7:0] mask,
                             input int unsigned dash_ticks);
    for (int unsigned i = 0; i < nsym; i++) begin
      press();
      repeat (mask[i] ? dash_ticks : 1) pulse_tick();
      check("timer_enable_mark", 32'(timer_enable), 32'd1);
      release_key();
      if (i + 1 < nsym) begin
        pulse_tick();
        check("no_letter_short_space", 32'(letter_valid), 32'd0);
      end
    end
  endtask

  // Space ticks 1..7 after the last symbol: letter at 3, word gap at 7.
  task automatic finish_letter(input string name, input logic [4:0] bits,
                               input logic [2:0] len, input logic err);
    pulse_tick();
    check({name, "_valid_t1"}, 32'(letter_valid), 32'd0);
    pulse_tick();
    check({name, "_valid_t2"}, 32'(letter_valid), 32'd0);
    pulse_tick();
    check({name, "_valid_t3"}, 32'(letter_valid), 32'd1);
    check({name, "_bits"}, 32'(letter_bits), 32'(bits));
    check({name, "_len"}, 32'(letter_len), 32'(len));
    check({name, "_err"}, 32'(letter_err), 32'(err));
    pulse_tick();
    check({name, "_valid_t4"}, 32'(letter_valid), 32'd0);
    check({name, "_bits_hold"}, 32'(letter_bits), 32'(bits));
    pulse_tick();
    pulse_tick();
    check({name, "_wordgap_t6"}, 32'(word_gap), 32'd0);
    pulse_tick();
    check({name, "_wordgap_t7"}, 32'(word_gap), 32'd1);
    step();
    check({name, "_wordgap_off"}, 32'(word_gap), 32'd0);
    check({name, "_timer_off"}, 32'(timer_enable), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"A_dot_dash",    2, 8'b0000_0010, 5'b00001, 3'd2, 1'b0};
    vecs[1] = '{"six_dots",      6, 8'b0000_0000, 5'b00000, 3'd5, 1'b1};
    vecs[2] = '{"B_dash_dots",   4, 8'b0000_0001, 5'b01000, 3'd4, 1'b0};
    vecs[3] = '{"five_dashes",   5, 8'b0001_1111, 5'b11111, 3'd5, 1'b0};
    vecs[4] = '{"T_dash",        1, 8'b0000_0001, 5'b00001, 3'd1, 1'b0};
    vecs[5] = '{"six_mixed_ovf", 6, 8'b0010_0001, 5'b10000, 3'd5, 1'b1};
    vecs[6] = '{"E_dot",         1, 8'b0000_0000, 5'b00000, 3'd1, 1'b0};

    // Reset state
    repeat (3) step();
    check("reset_timer_enable", 32'(timer_enable), 32'd0);
    check("reset_letter_valid", 32'(letter_valid), 32'd0);
    check("reset_letter_bits", 32'(letter_bits), 32'd0);
    check("reset_letter_len", 32'(letter_len), 32'd0);
    check("reset_word_gap", 32'(word_gap), 32'd0);
    rst = 1'b1;
    step();

    // Table-driven letters, each followed by a full word gap
    for (int i = 0; i < 7; i++) begin
      run_symbols(vecs[i].nsym, vecs[i].mask, 3);
      finish_letter(vecs[i].name, vecs[i].bits, vecs[i].len, vecs[i].err);
    end

    // Fall coincident with a tick at cnt=1: tick dropped, symbol stays a dot.
    // Rise at space tick 2 continues the same letter.
    press();
    pulse_tick();
    key = 1'b0;
    repeat (2) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    pulse_tick();
    pulse_tick();
    check("race_no_letter_t2", 32'(letter_valid), 32'd0);
    run_symbols(1, 8'b0000_0001, 3);
    finish_letter("race_dot_then_dash", 5'b00001, 3'd2, 1'b0);

    // Mark counter saturates instead of wrapping (17 ticks would wrap to 1)
    run_symbols(1, 8'b0000_0001, 17);
    finish_letter("saturate_dash", 5'b00001, 3'd1, 1'b0);

    // Clear during SPACE with three symbols buffered
    run_symbols(3, 8'b0000_0000, 3);
    pulse_tick();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_no_valid", 32'(letter_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      check("clear_idle_no_valid", 32'(letter_valid), 32'd0);
    end
    check("clear_timer_off", 32'(timer_enable), 32'd0);
    run_symbols(1, 8'b0000_0000, 3);
    finish_letter("after_clear_E", 5'b00000, 3'd1, 1'b0);

    // Async reset mid-MARK with key held
    press();
    pulse_tick();
    check("pre_reset_timer_on", 32'(timer_enable), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_timer", 32'(timer_enable), 32'd0);
    check("async_reset_valid", 32'(letter_valid), 32'd0);
    check("async_reset_len", 32'(letter_len), 32'd0);
    check("async_reset_word_gap", 32'(word_gap), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      check("post_reset_no_letter", 32'(letter_valid), 32'd0);
    end
    // Clear with key still held: must stay idle since no new rise arrives
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (3) step();
    check("held_key_clear_idle", 32'(timer_enable), 32'd0);
    release_key();
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      check("held_key_no_letter", 32'(letter_valid), 32'd0);
      check("held_key_no_word_gap", 32'(word_gap), 32'd0);
    end
    check("held_key_timer_off", 32'(timer_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
